// File: rtl/br_redirect.sv
// Branch-resolution redirect unit: turns resolved EXE branch results into fetch redirects,
// flushes and (with BR_REDIRECT_MIS_CHK_EN) misaligned-target exceptions.
module br_redirect #(
    parameter int PC_SZ  = 32,
    parameter int CNT_SZ = 16
) (
    input  logic              clk_in,
    input  logic              reset_n_in,

    input  logic              res_valid,
    output logic              res_ready,
    input  logic [PC_SZ-1:0]  res_pc,
    input  logic [PC_SZ-1:0]  res_br_pc,
    input  logic [PC_SZ-1:0]  res_no_br_pc,
    input  logic              res_taken,
    input  logic              res_pred_taken,
    input  logic [PC_SZ-1:0]  res_pred_pc,

    output logic              flush_out,

    output logic              redir_valid,
    output logic [PC_SZ-1:0]  redir_pc,
    input  logic              redir_ready,

    output logic              exc_valid,
    output logic [PC_SZ-1:0]  exc_pc,
    output logic [PC_SZ-1:0]  exc_tval,
    input  logic              exc_ready,

    output logic [CNT_SZ-1:0] mispred_cnt,
    output logic [1:0]        state_dbg
);

    // Handshakes (res, redir, exc): a transfer happens on a rising edge where valid
    // and ready are both 1; a producer holds valid and payload stable until then.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_EXC   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [PC_SZ-1:0]  target;
    logic              mispredict;
    logic              misalign;

    // res_ready is masked by reset so it reads 0 while reset is held.
    assign res_ready  = (state == ST_IDLE) && reset_n_in;
    assign accept     = res_valid && res_ready;
    assign target     = res_taken ? res_br_pc : res_no_br_pc;
    assign mispredict = (res_taken != res_pred_taken) ||
                        (res_taken && (res_br_pc != res_pred_pc));

`ifdef BR_REDIRECT_MIS_CHK_EN
    logic [PC_SZ-1:0] exc_pc_q;
    logic [PC_SZ-1:0] exc_tval_q;

    assign misalign  = res_taken && (res_br_pc[1:0] != 2'b00);
    assign exc_valid = (state == ST_EXC);
    assign exc_pc    = exc_pc_q;
    assign exc_tval  = exc_tval_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            exc_pc_q   <= '0;
            exc_tval_q <= '0;
        end else if (accept && misalign) begin
            exc_pc_q   <= res_pc;
            exc_tval_q <= res_br_pc;
        end
    end
`else
    // 2-byte aligned targets are legal here; res_pc only feeds the exception path.
    logic unused_res_pc;

    assign misalign      = 1'b0;
    assign exc_valid     = 1'b0;
    assign exc_pc        = '0;
    assign exc_tval      = '0;
    assign unused_res_pc = ^res_pc;
`endif

    assign redir_valid = (state == ST_REDIR);
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && misalign) begin
                    state_nxt = ST_EXC;
                end else if (accept && mispredict) begin
                    state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (redir_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_EXC: begin
                if (exc_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= ST_IDLE;
            flush_out   <= 1'b0;
            redir_pc    <= '0;
            mispred_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_out <= accept && (misalign || mispredict);
            // A misaligned target wins over a mispredict: no redirect, no count.
            if (accept && !misalign && mispredict) begin
                redir_pc <= target;
                if (mispred_cnt != {CNT_SZ{1'b1}}) begin
                    mispred_cnt <= mispred_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_br_redirect.sv
// Directed bench for br_redirect: driver pushes expected redirect/exception transfers
// into a queue, a negedge monitor pops and compares them on every handshake.
module tb_br_redirect;

    localparam int PC = 32;
    localparam int W  = 2 * PC + 1;

`ifdef BR_REDIRECT_MIS_CHK_EN
    localparam int MIS6 = 0;
`else
    localparam int MIS6 = 1;
`endif

    logic          clk_in = 1'b0;
    logic          reset_n_in;
    logic          res_valid;
    logic          res_ready;
    logic [PC-1:0] res_pc, res_br_pc, res_no_br_pc, res_pred_pc;
    logic          res_taken, res_pred_taken;
    logic          flush_out;
    logic          redir_valid;
    logic [PC-1:0] redir_pc;
    logic          redir_ready;
    logic          exc_valid;
    logic [PC-1:0] exc_pc, exc_tval;
    logic          exc_ready;
    logic [15:0]   mispred_cnt;
    logic [1:0]    state_dbg;

    logic          s_res_ready, s_flush, s_redir_valid, s_exc_valid;
    logic [PC-1:0] s_redir_pc, s_exc_pc, s_exc_tval;
    logic [1:0]    s_cnt;
    logic [1:0]    s_state;

    logic [W-1:0]  exp_q[$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk_in = ~clk_in;

    br_redirect #(.PC_SZ(PC), .CNT_SZ(16)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_br_pc(res_br_pc), .res_no_br_pc(res_no_br_pc),
        .res_taken(res_taken), .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc),
        .flush_out(flush_out),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_tval(exc_tval), .exc_ready(exc_ready),
        .mispred_cnt(mispred_cnt), .state_dbg(state_dbg)
    );

    // Narrow-counter copy driven with the same stimulus, for saturation.
    br_redirect #(.PC_SZ(PC), .CNT_SZ(2)) u_sat (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .res_valid(res_valid), .res_ready(s_res_ready),
        .res_pc(res_pc), .res_br_pc(res_br_pc), .res_no_br_pc(res_no_br_pc),
        .res_taken(res_taken), .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc),
        .flush_out(s_flush),
        .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .redir_ready(redir_ready),
        .exc_valid(s_exc_valid), .exc_pc(s_exc_pc), .exc_tval(s_exc_tval), .exc_ready(exc_ready),
        .mispred_cnt(s_cnt), .state_dbg(s_state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected actual=%0h required=none", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    always @(negedge clk_in) begin
        if (reset_n_in === 1'b1) begin
            if (redir_valid && redir_ready) sb_pop("sb_redir", {1'b0, redir_pc, {PC{1'b0}}});
            if (exc_valid && exc_ready)     sb_pop("sb_exc",   {1'b1, exc_pc, exc_tval});
        end
    end

    // Holds res_valid until accepted (bounded); returns #1 after the accepting edge.
    task automatic send(input logic [PC-1:0] pc, input logic [PC-1:0] br, input logic [PC-1:0] nobr,
                        input logic tk, input logic ptk, input logic [PC-1:0] ppc, output int waited);
        logic got;
        res_pc = pc; res_br_pc = br; res_no_br_pc = nobr;
        res_taken = tk; res_pred_taken = ptk; res_pred_pc = ppc;
        res_valid = 1'b1;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk_in);
            got = res_ready;
            waited++;
            @(posedge clk_in);
            #1;
        end
        res_valid = 1'b0;
        check("accept", {{(W-1){1'b0}}, got}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset_n_in = 1'b0; res_valid = 1'b0;
        res_pc = '0; res_br_pc = '0; res_no_br_pc = '0; res_pred_pc = '0;
        res_taken = 1'b0; res_pred_taken = 1'b0;
        redir_ready = 1'b1; exc_ready = 1'b1;

        #1;
        check("rst_flush", flush_out, 0);
        check("rst_redir_valid", redir_valid, 0);
        check("rst_exc_valid", exc_valid, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_cnt", mispred_cnt, 0);
        repeat (3) @(posedge clk_in);
        #1 reset_n_in = 1'b1;
        #1 check("post_rst_ready", res_ready, 1);

        // Correct taken prediction.
        send(32'h10, 32'h100, 32'h14, 1'b1, 1'b1, 32'h100, w);
        check("ok_flush", flush_out, 0);
        check("ok_redir_valid", redir_valid, 0);
        check("ok_cnt", mispred_cnt, 0);
        check("ok_ready", res_ready, 1);

        // Direction mispredict, fall-through target.
        exp_q.push_back({1'b0, 32'h204, 32'h0});
        send(32'h200, 32'h280, 32'h204, 1'b0, 1'b1, 32'h280, w);
        check("dir_flush", flush_out, 1);
        check("dir_redir_valid", redir_valid, 1);
        check("dir_redir_pc", redir_pc, 32'h204);
        check("dir_cnt", mispred_cnt, 1);
        check("dir_ready", res_ready, 0);
        @(posedge clk_in); #1;
        check("dir_flush_end", flush_out, 0);
        check("dir_idle", res_ready, 1);

        // Stalled fetch.
        redir_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h300, 32'h0});
        send(32'h30, 32'h300, 32'h34, 1'b1, 1'b0, 32'h0, w);
        for (int i = 0; i < 3; i++) begin
            check("stall_flush", flush_out, (i == 0) ? 1 : 0);
            check("stall_valid", redir_valid, 1);
            check("stall_pc", redir_pc, 32'h300);
            check("stall_ready", res_ready, 0);
            @(posedge clk_in); #1;
        end
        redir_ready = 1'b1;
        @(posedge clk_in); #1;
        check("stall_idle", state_dbg, 0);
        check("stall_res_ready", res_ready, 1);

        // Taken, right direction, wrong target.
        exp_q.push_back({1'b0, 32'h400, 32'h0});
        send(32'h44, 32'h400, 32'h48, 1'b1, 1'b1, 32'h404, w);
        check("tgt_pc", redir_pc, 32'h400);
        check("tgt_cnt", mispred_cnt, 3);
        @(posedge clk_in); #1;

        // Misaligned taken target.
`ifdef BR_REDIRECT_MIS_CHK_EN
        exp_q.push_back({1'b1, 32'h40, 32'h102});
        send(32'h40, 32'h102, 32'h44, 1'b1, 1'b0, 32'h0, w);
        check("mis_exc_valid", exc_valid, 1);
        check("mis_exc_pc", exc_pc, 32'h40);
        check("mis_exc_tval", exc_tval, 32'h102);
        check("mis_redir_valid", redir_valid, 0);
        check("mis_flush", flush_out, 1);
        check("mis_cnt", mispred_cnt, 3);
`else
        exp_q.push_back({1'b0, 32'h102, 32'h0});
        send(32'h40, 32'h102, 32'h44, 1'b1, 1'b0, 32'h0, w);
        check("mis_redir_pc", redir_pc, 32'h102);
        check("mis_exc_valid", exc_valid, 0);
        check("mis_cnt", mispred_cnt, 4);
`endif
        @(posedge clk_in); #1;
        check("mis_idle", state_dbg, 0);

        // Back-to-back mispredicts and counter saturation on the narrow copy.
        exp_q.push_back({1'b0, 32'h600, 32'h0});
        send(32'h60, 32'h600, 32'h64, 1'b1, 1'b0, 32'h0, w);
        exp_q.push_back({1'b0, 32'h700, 32'h0});
        send(32'h70, 32'h700, 32'h74, 1'b1, 1'b0, 32'h0, w);
        check("b2b_spacing", w, 2);
        check("cnt_total", mispred_cnt, 5 + MIS6);
        check("sat_cnt", s_cnt, 3);
        @(posedge clk_in); #1;

        // Reset mid-REDIR drops the pending redirect.
        redir_ready = 1'b0;
        send(32'h80, 32'h800, 32'h84, 1'b1, 1'b0, 32'h0, w);
        check("pre_rst_valid", redir_valid, 1);
        #2 reset_n_in = 1'b0;
        #1;
        check("mid_rst_flush", flush_out, 0);
        check("mid_rst_valid", redir_valid, 0);
        check("mid_rst_pc", redir_pc, 0);
        check("mid_rst_exc", {exc_valid, exc_pc, exc_tval}, 0);
        check("mid_rst_cnt", mispred_cnt, 0);
        check("mid_rst_sat_cnt", s_cnt, 0);
        check("mid_rst_ready", res_ready, 0);
        redir_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 reset_n_in = 1'b1;
        #1 check("rel_ready", res_ready, 1);
        repeat (4) @(posedge clk_in);
        #1;
        check("rel_no_stale", redir_valid, 0);
        check("rel_flush", flush_out, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_redirect.md
BR_REDIRECT -- requirements
Module: br_redirect

Interface
REQ-001 SHALL have parameter PC_SZ, default 32: width of all PC and address buses.
REQ-002 SHALL have parameter CNT_SZ, default 16: width of the mispredict counter.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port res_valid, input, 1 bit: a resolved branch/jump/xRET result from EXE is present.
REQ-006 SHALL have port res_ready, output, 1 bit: the block accepts a result.
REQ-007 SHALL have ports res_pc, res_br_pc and res_no_br_pc, inputs, PC_SZ each: instruction PC, taken target, and fall-through PC.
REQ-008 SHALL have ports res_taken and res_pred_taken, inputs, 1 bit each: resolved direction and fetch-predicted direction.
REQ-009 SHALL have port res_pred_pc, input, PC_SZ: fetch-predicted target.
REQ-010 SHALL have port flush_out, output, 1 bit: one-cycle pulse that kills younger instructions in the IF/ID/EXE stages.
REQ-011 SHALL have ports redir_valid (output, 1), redir_pc (output, PC_SZ) and redir_ready (input, 1): fetch redirect handshake.
REQ-012 SHALL have ports exc_valid (output, 1), exc_pc (output, PC_SZ), exc_tval (output, PC_SZ) and exc_ready (input, 1): misaligned-target exception handshake to the CSR/trap unit.
REQ-013 SHALL have port mispred_cnt, output, CNT_SZ: saturating count of mispredicts.

Function
REQ-014 SHALL accept a result when res_valid and res_ready are both 1 in the same cycle; res_ready SHALL be 1 only in state IDLE.
REQ-015 SHALL compute the target as res_br_pc when res_taken is 1, and as res_no_br_pc otherwise.
REQ-016 SHALL flag a mispredict when res_taken differs from res_pred_taken, or when res_taken is 1 and res_br_pc differs from res_pred_pc.
REQ-017 SHALL flag a misalign when res_taken is 1 and res_br_pc[1:0] is nonzero; misalign SHALL take priority over mispredict.
REQ-018 SHALL use three states: IDLE, REDIR and EXC.
REQ-019 IDLE, accepted result that is neither a mispredict nor a misalign: SHALL stay in IDLE with no output activity.
REQ-020 IDLE, accepted mispredict: SHALL go to REDIR next cycle, register redir_pc as the target, pulse flush_out for exactly that first cycle, and increment mispred_cnt.
REQ-021 REDIR: SHALL hold redir_valid at 1 and redir_pc stable until redir_ready is 1, then return to IDLE the following cycle.
REQ-022 IDLE, accepted misalign: SHALL go to EXC, pulse flush_out for one cycle, set exc_pc to res_pc and exc_tval to res_br_pc, and hold exc_valid until exc_ready is 1, then return to IDLE; no redirect SHALL be issued.
REQ-023 Latency: accept to flush_out/redir_valid/exc_valid SHALL be 1 cycle; minimum back-to-back redirect spacing SHALL be 2 cycles.
REQ-024 SHALL saturate mispred_cnt at all-ones and never wrap.
REQ-025 SHALL ignore redir_ready and exc_ready in states where the matching valid is 0.
REQ-026 SHALL perform all PC compares at full PC_SZ width.

Reset
REQ-027 Asserting reset_n_in low at any time, including mid-REDIR or mid-EXC, SHALL immediately force state IDLE, flush_out, redir_valid and exc_valid to 0, redir_pc, exc_pc, exc_tval and mispred_cnt to 0, and res_ready to 0 while reset is held; any pending redirect or exception SHALL be dropped.
REQ-028 res_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 With macro BR_REDIRECT_MIS_CHK_EN defined, SHALL implement the misalign check and EXC state as specified.
REQ-030 With BR_REDIRECT_MIS_CHK_EN undefined, SHALL never flag a misalign, SHALL tie exc_valid, exc_pc and exc_tval to 0, and SHALL treat every taken target as a normal redirect (matches C-extension targets that are 2-byte aligned).

Verification
REQ-031 Correct prediction: accept with res_taken=1, res_pred_taken=1, res_br_pc=res_pred_pc=0x100 -> no flush, redir_valid stays 0, count unchanged.
REQ-032 Direction mispredict: accept with res_taken=0, res_pred_taken=1, res_no_br_pc=0x204 -> next cycle flush_out=1 for 1 cycle, redir_pc=0x204, count=1.
REQ-033 Stalled fetch: mispredict with target 0x300 and redir_ready=0 for 3 cycles -> redir_valid and redir_pc=0x300 held 3 cycles, res_ready=0, IDLE one cycle after redir_ready=1.
REQ-034 Misalign with the macro defined: res_pc=0x40, res_taken=1, res_br_pc=0x102 -> exc_valid=1, exc_tval=0x102, exc_pc=0x40, redir_valid=0; with the macro undefined -> redir_pc=0x102.
REQ-035 Reset mid-REDIR: reset_n_in low while redir_valid=1 -> all outputs 0 immediately; after release res_ready=1 and no stale redirect appears.
REQ-036 Saturation: CNT_SZ=2 with 5 mispredicts -> mispred_cnt=3.
